// File: rtl/fp_accumulate_seq.sv
// fp_accumulate_seq: sequential front-end for an external combinational
// binary32 adder. Sums a frame of samples arriving on a valid/ready stream
// and presents the total and the sample count on a valid/ready output.
// The adder sits beside this block: add_a/add_b go out, add_sum comes back.
module fp_accumulate_seq #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] frame_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    output logic [31:0]        add_a,
    output logic [31:0]        add_b,
    input  logic [31:0]        add_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [COUNT_W-1:0] out_count,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        ADD    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        opnd_q, opnd_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] len_q, len_d;

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // Next-state logic: one capture cycle then one add cycle per sample.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (frame_len != '0) begin
                        len_d   = frame_len;
                        state_d = ACCEPT;
                    end else begin
                        // Empty frame: report +0 with a count of zero.
                        state_d = DONE;
                    end
                end
            end
            ACCEPT: begin
                if (in_valid) begin
                    opnd_d  = in_data;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                // Operands have been stable all cycle, so add_sum has settled.
                acc_d   = add_sum;
                state_d = (cnt_q == len_q) ? DONE : ACCEPT;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on state and registers: no input-to-output path.
    assign in_ready  = (state_q == ACCEPT);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign add_a     = acc_q;
    assign add_b     = opnd_q;
    assign out_data  = out_valid ? acc_q : 32'h0;
    assign out_count = out_valid ? cnt_q : '0;

endmodule

// File: tb/tb_fp_accumulate_seq.sv
// Directed bench for fp_accumulate_seq with a behavioural binary32 adder
// standing in for the real one. Inputs are driven and outputs sampled on
// the falling edge.
module tb_fp_accumulate_seq;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n, start, in_valid, in_ready, out_valid, out_ready, busy;
    logic [CW-1:0] frame_len, out_count;
    logic [31:0]   in_data, add_a, add_b, add_sum, out_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_accumulate_seq #(.COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .busy(busy)
    );

    // binary32 -> binary64 bit pattern (normals, zeros, inf/NaN; no subnormals)
    function automatic logic [63:0] widen(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'h00)      e = 11'h000;
        else if (f[30:23] == 8'hFF) e = 11'h7FF;
        else                        e = {3'b000, f[30:23]} + 11'd896;
        if (f[30:23] == 8'h00) return {f[31], 63'h0};
        return {f[31], e, f[22:0], 29'h0};
    endfunction

    // Behavioural adder: adds in double, narrows by truncation, default NaN.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        real         r;
        logic [63:0] rb;
        logic [10:0] e;
        r  = $bitstoreal(widen(a)) + $bitstoreal(widen(b));
        rb = $realtobits(r);
        if (rb[62:52] == 11'h7FF)
            return (rb[51:0] != 52'h0) ? 32'hFFC00000 : {rb[63], 8'hFF, 23'h0};
        if (rb[62:52] == 11'h000) return {rb[63], 31'h0};
        e = rb[62:52] - 11'd896;
        return {rb[63], e[7:0], rb[51:29]};
    endfunction

    always_comb add_sum = fadd(add_a, add_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one sample once the block is ready, hold it for the capture edge.
    task automatic feed(input logic [31:0] d);
        int g = 0;
        while (!in_ready && g < 20) begin tick(); g++; end
        if (!in_ready) chk("feed_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = 32'hDEADBEEF;
    endtask

    task automatic wait_valid(input string tag);
        int g = 0;
        while (!out_valid && g < 20) begin tick(); g++; end
        if (!out_valid) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic pulse_start(input logic [CW-1:0] len);
        start     = 1'b1;
        frame_len = len;
        tick();
        start     = 1'b0;
        frame_len = 8'hAA;
    endtask

    initial begin
        int caps;
        logic [5:0] vpat;
        logic [31:0] dpat [6];
        rst_n = 1'b0; start = 1'b0; frame_len = '0; in_valid = 1'b0;
        in_data = 32'h0; out_ready = 1'b0;
        @(negedge clk);
        tick();
        // Reset state
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_count", {24'h0, out_count}, 32'd0);
        chk("rst_add_a", add_a, 32'h0);
        chk("rst_add_b", add_b, 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic sum 1+2+3 with in_valid held high
        out_ready = 1'b1;
        pulse_start(8'd3);
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        chk("basic_rdy0", {31'h0, in_ready}, 32'd1);
        tick();
        chk("basic_add0_rdy", {31'h0, in_ready}, 32'd0);
        chk("basic_add0_b", add_b, 32'h3F800000);
        in_data = 32'h40000000;
        tick();
        chk("basic_rdy1", {31'h0, in_ready}, 32'd1);
        chk("basic_acc1", add_a, 32'h3F800000);
        tick();
        in_data = 32'h40400000;
        tick();
        chk("basic_rdy2", {31'h0, in_ready}, 32'd1);
        tick();
        chk("basic_add2_b", add_b, 32'h40400000);
        chk("basic_add2_nov", {31'h0, out_valid}, 32'd0);
        in_valid = 1'b0;
        tick();
        chk("basic_valid", {31'h0, out_valid}, 32'd1);
        chk("basic_data", out_data, 32'h40C00000);
        chk("basic_count", {24'h0, out_count}, 32'd3);
        tick();
        chk("basic_idle_busy", {31'h0, busy}, 32'd0);
        chk("basic_idle_ov", {31'h0, out_valid}, 32'd0);

        // Zero-length frame
        out_ready = 1'b0;
        pulse_start(8'd0);
        chk("zero_valid", {31'h0, out_valid}, 32'd1);
        chk("zero_data", out_data, 32'h0);
        chk("zero_count", {24'h0, out_count}, 32'd0);
        chk("zero_in_ready", {31'h0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("zero_idle", {31'h0, busy}, 32'd0);

        // Special values: +inf + -inf -> default NaN from the adder
        pulse_start(8'd2);
        feed(32'h7F800000);
        feed(32'hFF800000);
        wait_valid("inf_timeout");
        chk("inf_data", out_data, 32'hFFC00000);
        chk("inf_count", {24'h0, out_count}, 32'd2);
        tick();

        // Back-pressure with an ignored start during DONE
        out_ready = 1'b0;
        pulse_start(8'd2);
        feed(32'h3F800000);
        feed(32'h3F800000);
        wait_valid("bp_timeout");
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", {31'h0, out_valid}, 32'd1);
            chk("bp_hold_data", out_data, 32'h40000000);
            start = (i == 2); frame_len = 8'd1;
            tick();
            start = 1'b0;
        end
        chk("bp_after_start_data", out_data, 32'h40000000);
        out_ready = 1'b1;
        tick();
        chk("bp_idle_busy", {31'h0, busy}, 32'd0);
        tick();
        chk("bp_start_ignored", {31'h0, busy}, 32'd0);

        // Input stalls: in_valid 1,0,0,1,0,1, junk data when not valid
        pulse_start(8'd3);
        vpat = 6'b101001;  // bit i = in_valid in cycle i
        dpat = '{32'h3F000000, 32'h12345678, 32'h12345678,
                 32'h3E800000, 32'h12345678, 32'h3E800000};
        caps = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = vpat[i];
            in_data  = dpat[i];
            if (in_valid && in_ready) caps++;
            tick();
        end
        in_valid = 1'b0;
        wait_valid("stall_timeout");
        chk("stall_caps", caps, 32'd3);
        chk("stall_data", out_data, 32'h3F800000);
        chk("stall_count", {24'h0, out_count}, 32'd3);
        tick();

        // Reset mid-frame, then a fresh one-sample frame
        pulse_start(8'd4);
        feed(32'h3F800000);
        feed(32'h3F800000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_busy", {31'h0, busy}, 32'd0);
        chk("mid_rst_acc", add_a, 32'h0);
        caps = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) caps++;
            tick();
        end
        chk("mid_rst_no_out", caps, 32'd0);
        pulse_start(8'd1);
        feed(32'h40A00000);
        wait_valid("mid_new_timeout");
        chk("mid_new_data", out_data, 32'h40A00000);
        chk("mid_new_count", {24'h0, out_count}, 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
